// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for a bank of ultrasonic range sensors: trigger one
// sensor, time its echo with a timeout, report, hold off, move to the next.
//
// state     | meaning
// IDLE      | scan stopped, waiting for enable
// TRIG      | trig[sel] driven high for TRIG_CYCLES cycles
// WAIT_RISE | waiting for a fresh rising edge on echo[sel], timeout running
// MEASURE   | counting echo-high samples, timeout still running
// HOLDOFF   | quiet gap after a report before the next sensor fires
module ultrasonic_scheduler #(
  parameter int NUM_SENSORS    = 4,
  parameter int SEL_W          = 2,
  parameter int TRIG_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                   pclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   busy,
  output logic                   result_valid,
  output logic [SEL_W-1:0]       result_sel,
  output logic [CNT_W-1:0]       result_count,
  output logic                   result_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  localparam logic [CNT_W-1:0]       TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]       HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0]       TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
  localparam logic [SEL_W-1:0]       SEL_LAST  = SEL_W'(NUM_SENSORS - 1);
  localparam logic [NUM_SENSORS-1:0] TRIG_ONE  = NUM_SENSORS'(1);

  state_t                   state_q, state_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]         dcnt_q, dcnt_d;
  logic [CNT_W-1:0]         tmr_q, tmr_d;
  logic [CNT_W-1:0]         wcnt_q, wcnt_d;
  logic [NUM_SENSORS-1:0]   echo_q;
  logic [NUM_SENSORS-1:0]   trig_q, trig_d;
  logic                     busy_q, busy_d;
  logic                     rv_q, rv_d;
  logic [SEL_W-1:0]         rsel_q, rsel_d;
  logic [CNT_W-1:0]         rcnt_q, rcnt_d;
  logic                     rto_q, rto_d;

  logic                     echo_cur;
  logic                     echo_old;
  logic                     report;
  logic [CNT_W-1:0]         rep_cnt;
  logic                     rep_to;
  logic [SEL_W-1:0]         sel_next;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dcnt_q  <= '0;
      tmr_q   <= '0;
      wcnt_q  <= '0;
      echo_q  <= '0;
      trig_q  <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      rsel_q  <= '0;
      rcnt_q  <= '0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dcnt_q  <= dcnt_d;
      tmr_q   <= tmr_d;
      wcnt_q  <= wcnt_d;
      echo_q  <= echo;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      rsel_q  <= rsel_d;
      rcnt_q  <= rcnt_d;
      rto_q   <= rto_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dcnt_d   = dcnt_q;
    tmr_d    = tmr_q;
    wcnt_d   = wcnt_q;
    rv_d     = 1'b0;
    rsel_d   = rsel_q;
    rcnt_d   = rcnt_q;
    rto_d    = rto_q;
    report   = 1'b0;
    rep_cnt  = '0;
    rep_to   = 1'b0;
    echo_cur = echo[sel_q];
    echo_old = echo_q[sel_q];
    sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          dcnt_d  = TRIG_LAST;
        end
      end

      TRIG: begin
        if (dcnt_q == '0) begin
          state_d = WAIT_RISE;
          tmr_d   = '0;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end

      // A rise on the last window cycle cannot start a measurement that
      // could never be timed out, so the timeout takes priority here.
      WAIT_RISE: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TMO_LAST) begin
          report = 1'b1;
          rep_to = 1'b1;
        end else if (echo_cur && !echo_old) begin
          state_d = MEASURE;
          wcnt_d  = CNT_W'(1);
        end
      end

      MEASURE: begin
        tmr_d = tmr_q + 1'b1;
        if (!echo_cur) begin
          report  = 1'b1;
          rep_cnt = wcnt_q;
        end else begin
          if (wcnt_q != CNT_MAX) begin
            wcnt_d = wcnt_q + 1'b1;
          end
          if (tmr_q == TMO_LAST) begin
            report  = 1'b1;
            rep_to  = 1'b1;
            rep_cnt = wcnt_q;
          end
        end
      end

      HOLDOFF: begin
        if (dcnt_q == '0) begin
          sel_d = sel_next;
          if (enable) begin
            state_d = TRIG;
            dcnt_d  = TRIG_LAST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Hold-off counts down through zero, so the next trigger lands
    // HOLDOFF_CYCLES+1 cycles after the result pulse.
    if (report) begin
      state_d = HOLDOFF;
      dcnt_d  = HOLD_LOAD;
      rv_d    = 1'b1;
      rsel_d  = sel_q;
      rcnt_d  = rep_cnt;
      rto_d   = rep_to;
    end
  end

  assign trig_d = (state_d == TRIG) ? (TRIG_ONE << sel_d) : '0;
  assign busy_d = (state_d != IDLE);

  assign trig           = trig_q;
  assign busy           = busy_q;
  assign result_valid   = rv_q;
  assign result_sel     = rsel_q;
  assign result_count   = rcnt_q;
  assign result_timeout = rto_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler: table of per-sensor measurements
// plus hand-written enable-drop and mid-measurement reset sequences.
module tb_ultrasonic_scheduler;
  localparam int NS    = 4;
  localparam int SW    = 2;
  localparam int TRIGC = 10;
  localparam int TMO   = 200;
  localparam int HOLD  = 20;
  localparam int CW    = 16;
  localparam int LIMIT = 400;

  logic          pclk   = 1'b0;
  logic          reset  = 1'b1;
  logic          enable = 1'b0;
  logic [NS-1:0] echo   = '0;
  logic [NS-1:0] trig;
  logic          busy;
  logic          result_valid;
  logic [SW-1:0] result_sel;
  logic [CW-1:0] result_count;
  logic          result_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sel;
    int pre_len;
    int delay;
    int width;
    int xt_mask;
    int drop_k;
    int exp_count;
    int exp_to;
    int exp_lat;
    int gap_chk;
  } row_t;

  row_t rows [14];

  ultrasonic_scheduler #(
    .NUM_SENSORS   (NS),
    .SEL_W         (SW),
    .TRIG_CYCLES   (TRIGC),
    .TIMEOUT_CYCLES(TMO),
    .HOLDOFF_CYCLES(HOLD),
    .CNT_W         (CW)
  ) dut (
    .pclk          (pclk),
    .reset         (reset),
    .enable        (enable),
    .echo          (echo),
    .trig          (trig),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_sel    (result_sel),
    .result_count  (result_count),
    .result_timeout(result_timeout)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    chk("trig_onehot", 32'($countones(trig) <= 1), 1);
  endtask

  // Wait for the sensor's trigger, check it, drive the echo profile
  // relative to the cycle trig falls (k=0), then check the result.
  task automatic run_row(input row_t r);
    int gap;
    int tw;
    int k;
    logic [NS-1:0] mask;
    mask = NS'(1) << r.sel;
    if (r.pre_len > 0) echo[r.sel] = 1'b1;
    gap = 1;
    while (trig == '0 && gap < LIMIT) begin
      step();
      gap++;
    end
    chk("trig_sel", 32'(trig), 32'(mask));
    if (r.gap_chk != 0) chk("trig_gap", gap, HOLD + 1);
    tw = 0;
    while (trig == mask && tw < LIMIT) begin
      step();
      tw++;
    end
    chk("trig_width", tw, TRIGC);
    k = 0;
    while (k < LIMIT) begin
      echo[r.sel] = (k < r.pre_len) || (k >= r.delay && k < r.delay + r.width);
      echo = echo ^ NS'(r.xt_mask);
      if (r.drop_k != 0 && k == r.drop_k) enable = 1'b0;
      step();
      k++;
      if (result_valid) break;
    end
    chk("result_seen", 32'(result_valid), 1);
    chk("result_lat", k, r.exp_lat);
    chk("result_sel", 32'(result_sel), r.sel);
    chk("result_count", 32'(result_count), r.exp_count);
    chk("result_timeout", 32'(result_timeout), r.exp_to);
    chk("busy_run", 32'(busy), 1);
    echo = '0;
    step();
    chk("result_pulse", 32'(result_valid), 0);
  endtask

  initial begin
    int n;
    bit quiet;
    //          sel pre dly width  xt drop cnt  to lat  gap
    rows[0]  = '{0, 0,  5,  25,    0, 0,   25,  0, 31,  0};
    rows[1]  = '{1, 0,  2,  100,   0, 0,   100, 0, 103, 1};
    rows[2]  = '{2, 0,  0,  3,     0, 0,   3,   0, 4,   1};
    rows[3]  = '{3, 0,  10, 50,    0, 0,   50,  0, 61,  1};
    rows[4]  = '{0, 0,  1,  7,     0, 0,   7,   0, 9,   1};
    rows[5]  = '{1, 4,  8,  12,    8, 0,   12,  0, 21,  1};
    rows[6]  = '{2, 0,  0,  0,     0, 0,   0,   1, 200, 1};
    rows[7]  = '{3, 0,  50, 10000, 0, 0,   149, 1, 200, 1};
    rows[8]  = '{0, 0,  20, 179,   0, 0,   179, 0, 200, 1};
    rows[9]  = '{1, 0,  20, 180,   0, 0,   179, 1, 200, 1};
    rows[10] = '{2, 0,  4,  1,     0, 0,   1,   0, 6,   1};
    rows[11] = '{3, 0,  5,  30,    0, 10,  30,  0, 36,  1};
    rows[12] = '{0, 0,  3,  5,     0, 0,   5,   0, 9,   0};
    rows[13] = '{0, 0,  2,  9,     0, 0,   9,   0, 12,  0};

    reset = 1'b1;
    repeat (3) step();
    chk("rst_trig", 32'(trig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_sel", 32'(result_sel), 0);
    chk("rst_count", 32'(result_count), 0);
    chk("rst_timeout", 32'(result_timeout), 0);
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);
    enable = 1'b1;

    for (int i = 0; i <= 10; i++) run_row(rows[i]);

    // enable dropped mid-measurement: sensor completes, then IDLE
    run_row(rows[11]);
    repeat (HOLD - 1) step();
    chk("drop_busy_holdoff", 32'(busy), 1);
    step();
    chk("drop_busy_idle", 32'(busy), 0);
    chk("drop_trig_idle", 32'(trig), 0);
    repeat (10) step();
    chk("drop_stays_idle", 32'(busy | (trig != '0)), 0);

    // wrap back to sensor 0 after re-enable
    enable = 1'b1;
    run_row(rows[12]);

    // reset in the middle of sensor 1's measurement
    n = 1;
    while (trig == '0 && n < LIMIT) begin
      step();
      n++;
    end
    chk("rst_seq_trig_sel", 32'(trig), 32'b0010);
    n = 0;
    while (trig != '0 && n < LIMIT) begin
      step();
      n++;
    end
    repeat (3) step();
    echo[1] = 1'b1;
    repeat (6) step();
    reset = 1'b1;
    step();
    chk("mid_rst_trig", 32'(trig), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(result_valid), 0);
    chk("mid_rst_sel", 32'(result_sel), 0);
    chk("mid_rst_count", 32'(result_count), 0);
    chk("mid_rst_timeout", 32'(result_timeout), 0);
    reset  = 1'b0;
    enable = 1'b0;
    echo   = '0;
    quiet  = 1'b1;
    repeat (40) begin
      step();
      if (result_valid || busy || trig != '0) quiet = 1'b0;
    end
    chk("mid_rst_quiet", 32'(quiet), 1);
    enable = 1'b1;
    run_row(rows[13]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
